dtcm_arbiter: RTL and testbench

DTCM_ARBITER -- requirements
Module: dtcm_arbiter

---
 rtl/dtcm_arbiter.sv | 75 +++++++
 tb/tb_dtcm_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: arbitrates core and ext masters onto one single-port DTCM SRAM,
// with a starvation guard for ext and a one-cycle registered response path.
module dtcm_arbiter #(
    parameter int AW           = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          cpurst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [3:0]    core_be,
    input  logic [AW+1:0] core_addr,
    input  logic [31:0]   core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [31:0]   core_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [3:0]    ext_be,
    input  logic [AW+1:0] ext_addr,
    input  logic [31:0]   ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [31:0]   ext_rdata,
    output logic          sram_cs,
    output logic          sram_we,
    output logic [3:0]    sram_be,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, RSP_CORE, RSP_EXT} rsp_e;

    rsp_e          state_q;
    logic          rd_q;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved, wr;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^{core_addr[1:0], ext_addr[1:0]};

    // Every output is gated by cpurst so the block is silent throughout reset.
    assign starved  = starve_cnt_q == CW'(STARVE_LIMIT);
    assign ext_gnt  = cpurst & ext_req & (~core_req | starved);
    assign core_gnt = cpurst & core_req & ~ext_gnt;
    assign sram_cs  = core_gnt | ext_gnt;
    assign wr       = ext_gnt ? ext_we : core_we;

    assign sram_we    = sram_cs & wr;
    assign sram_be    = !sram_cs ? 4'h0 : !wr ? 4'hF : ext_gnt ? ext_be : core_be;
    assign sram_addr  = !sram_cs ? '0 : ext_gnt ? ext_addr[AW+1:2] : core_addr[AW+1:2];
    assign sram_wdata = !sram_cs ? '0 : ext_gnt ? ext_wdata : core_wdata;

    assign starve_cnt_d = (!ext_req || ext_gnt) ? '0 :
                          starved ? starve_cnt_q : starve_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!cpurst) begin
            state_q      <= IDLE;
            rd_q         <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= core_gnt ? RSP_CORE : ext_gnt ? RSP_EXT : IDLE;
            rd_q         <= sram_cs & ~wr;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign core_rvalid = cpurst & (state_q == RSP_CORE);
    assign ext_rvalid  = cpurst & (state_q == RSP_EXT);
    assign core_rdata  = (core_rvalid & rd_q) ? sram_rdata : '0;
    assign ext_rdata   = (ext_rvalid & rd_q) ? sram_rdata : '0;
endmodule

// File: tb/tb_dtcm_arbiter.sv
// tb_dtcm_arbiter: directed + randomized bench with a behavioural SRAM and a
// reference model of arbitration, starvation and responses, checked every cycle.
module tb_dtcm_arbiter;
    localparam int AW  = 12;
    localparam int LIM = 4;
    localparam int NW  = 1 << AW;

    logic          clk = 1'b0;
    logic          cpurst = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [3:0]    core_be = 4'h0;
    logic [AW+1:0] core_addr = '0;
    logic [31:0]   core_wdata = '0;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [3:0]    ext_be = 4'h0;
    logic [AW+1:0] ext_addr = '0;
    logic [31:0]   ext_wdata = '0;
    logic          core_gnt, core_rvalid, ext_gnt, ext_rvalid;
    logic [31:0]   core_rdata, ext_rdata;
    logic          sram_cs, sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dtcm_arbiter #(.AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .cpurst(cpurst),
        .core_req(core_req), .core_we(core_we), .core_be(core_be),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] init_word(input logic [AW-1:0] a);
        return {a, 4'h5, a, 4'hC} ^ 32'h3C96_A55A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Behavioural SRAM: preloaded on the first edge, byte-lane writes, 1-cycle read.
    logic [31:0] mem [0:NW-1];
    logic        pre_done = 1'b0;
    always @(posedge clk) begin
        if (!pre_done) begin
            for (int i = 0; i < NW; i++) mem[i] <= init_word(i[AW-1:0]);
            pre_done <= 1'b1;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_be);
            else sram_rdata <= mem[sram_addr];
        end
    end

    // Reference model and per-cycle comparison.
    logic [31:0] ref_mem [0:NW-1];
    initial begin
        int          cnt, rsp;
        logic        rsp_rd, eg, cg, wr;
        logic [31:0] rsp_dat, wd;
        logic [3:0]  be;
        logic [AW-1:0] a;
        cnt = 0; rsp = 0; rsp_rd = 1'b0; rsp_dat = '0;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i[AW-1:0]);
        forever begin
            @(negedge clk);
            if (!cpurst) begin
                check("m_rst_ctl", {core_gnt, ext_gnt, core_rvalid, ext_rvalid, sram_cs, sram_we, sram_be}, 0);
                check("m_rst_rdata", {core_rdata, ext_rdata}, 0);
                check("m_rst_sram", {sram_addr, sram_wdata}, 0);
                cnt = 0; rsp = 0;
            end else begin
                eg = ext_req && (!core_req || cnt == LIM);
                cg = core_req && !eg;
                check("m_gnt", {core_gnt, ext_gnt}, {cg, eg});
                check("m_rvalid", {core_rvalid, ext_rvalid}, {rsp == 1, rsp == 2});
                check("m_core_rdata", core_rdata, (rsp == 1 && rsp_rd) ? rsp_dat : 32'h0);
                check("m_ext_rdata", ext_rdata, (rsp == 2 && rsp_rd) ? rsp_dat : 32'h0);
                wr = eg ? ext_we : core_we;
                be = eg ? ext_be : core_be;
                wd = eg ? ext_wdata : core_wdata;
                a  = AW'((eg ? ext_addr : core_addr) >> 2);
                if (cg || eg) begin
                    check("m_sram_ctl", {sram_cs, sram_we, sram_be}, {1'b1, wr, wr ? be : 4'hF});
                    check("m_sram_addr", sram_addr, a);
                    check("m_sram_wdata", sram_wdata, wd);
                    rsp_rd  = !wr;
                    rsp_dat = ref_mem[a];
                    if (wr) ref_mem[a] = merge(ref_mem[a], wd, be);
                end else begin
                    check("m_sram_idle", {sram_cs, sram_we, sram_be}, 0);
                end
                rsp = cg ? 1 : eg ? 2 : 0;
                cnt = (!ext_req || eg) ? 0 : (cnt < LIM ? cnt + 1 : LIM);
            end
        end
    end

    task automatic go(input logic rst, input logic cr, input logic cw, input logic [3:0] cb,
                      input logic [15:0] ca, input logic [31:0] cd, input logic er, input logic ew,
                      input logic [3:0] eb, input logic [15:0] ea, input logic [31:0] ed);
        @(posedge clk);
        #1;
        cpurst = rst;
        core_req = cr; core_we = cw; core_be = cb; core_addr = ca[AW+1:0]; core_wdata = cd;
        ext_req = er; ext_we = ew; ext_be = eb; ext_addr = ea[AW+1:0]; ext_wdata = ed;
        @(negedge clk);
    endtask

    task automatic idle();
        go(1, 0, 0, 4'h0, 16'h0, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] iw;
        repeat (3) go(0, 1, 0, 4'hF, 16'h8, 32'h0, 1, 0, 4'hF, 16'hC, 32'h0);
        check("reset_outs", {core_gnt, ext_gnt, core_rvalid, ext_rvalid, sram_cs}, 0);

        // Partial write then read-back of word 4.
        go(1, 1, 1, 4'b0011, 16'h10, 32'hA5A5_1234, 0, 0, 4'h0, 16'h0, 32'h0);
        check("wr_gnt", {core_gnt, sram_we, sram_be, sram_addr}, {1'b1, 1'b1, 4'b0011, 12'h004});
        go(1, 1, 0, 4'h0, 16'h10, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0);
        check("wr_ack", {core_rvalid, core_rdata}, {1'b1, 32'h0});
        check("rd_be", sram_be, 4'hF);
        idle();
        iw = init_word(12'h004);
        check("rd_data", {core_rvalid, core_rdata}, {1'b1, iw[31:16], 16'h1234});
        idle();
        check("rvalid_once", core_rvalid, 0);

        // Both held: ext forced on the 5th and 10th cycles.
        for (int i = 0; i < 10; i++) begin
            go(1, 1, 0, 4'hF, 16'h100, 32'h0, 1, 0, 4'hF, 16'h200, 32'h0);
            check("starve_gnt", {core_gnt, ext_gnt}, (i == 4 || i == 9) ? 2'b01 : 2'b10);
        end
        idle();

        // Address wrap on ext reads.
        go(1, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'h3FFC, 32'h0);
        check("wrap_hi", sram_addr, 12'hFFF);
        go(1, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'h4000, 32'h0);
        check("wrap_lo", sram_addr, 12'h000);
        check("wrap_hi_data", {ext_rvalid, ext_rdata}, {1'b1, init_word(12'hFFF)});
        idle();
        check("wrap_lo_data", ext_rdata, init_word(12'h000));

        // Alternating core/ext reads every cycle.
        for (int i = 0; i < 7; i++) begin
            if (i == 6) idle();
            else if (i % 2 == 0) go(1, 1, 0, 4'h0, 16'(16'h40 + 4 * i), 32'h0, 0, 0, 4'h0, 16'h0, 32'h0);
            else go(1, 0, 0, 4'h0, 16'h0, 32'h0, 1, 0, 4'h0, 16'(16'h40 + 4 * i), 32'h0);
            if (i > 0) begin
                check("alt_port", {core_rvalid, ext_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
                check("alt_leak", (i % 2 == 1) ? ext_rdata : core_rdata, 0);
                check("alt_data", core_rdata | ext_rdata, init_word(12'(16 + i - 1)));
            end
        end

        // Reset in the cycle after a grant drops the response.
        go(1, 1, 0, 4'h0, 16'h20, 32'h0, 0, 0, 4'h0, 16'h0, 32'h0);
        go(0, 1, 0, 4'h0, 16'h20, 32'h0, 1, 0, 4'h0, 16'h24, 32'h0);
        check("rst_drop", {core_gnt, ext_gnt, core_rvalid, ext_rvalid, sram_cs, sram_we, sram_be}, 0);
        check("rst_rdata", {core_rdata, ext_rdata}, 0);
        idle();
        check("rst_no_rvalid", {core_rvalid, ext_rvalid}, 0);

        // ext drops after 3 denials: the count restarts.
        for (int i = 0; i < 3; i++) go(1, 1, 0, 4'h0, 16'h30, 32'h0, 1, 0, 4'h0, 16'h34, 32'h0);
        go(1, 1, 0, 4'h0, 16'h30, 32'h0, 0, 0, 4'h0, 16'h34, 32'h0);
        for (int i = 0; i < 5; i++) begin
            go(1, 1, 0, 4'h0, 16'h30, 32'h0, 1, 0, 4'h0, 16'h34, 32'h0);
            check("restart_gnt", ext_gnt, i == 4);
        end

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ca, ea;
            ca = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            ea = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            go($urandom_range(0, 99) != 0,
               $urandom_range(0, 9) < 6, 1'($urandom), 4'($urandom), ca, $urandom,
               $urandom_range(0, 9) < 6, 1'($urandom), 4'($urandom), ea, $urandom);
        end
        idle();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
